nibble_ctrl: RTL and testbench

Multi-cycle control sequencer for the nibble datapath. It owns the 4-bit program counter and sequences every instruction through fetch, instruction-register load, decode, execute and store. It drives the load enables of the instruction and decode-field registers, the add/subtract select of the ALU mux, and the RAM write strobe. It sits directly upstream of the PC/ROM/instruction-register/decoder/ALU/RAM chain and consumes the decoded opcode and ALU status flags.

---
 rtl/nibble_ctrl.sv | 129 ++++++++++++
 tb/tb_nibble_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_ctrl.sv
// Multi-cycle FETCH/IR/DEC/EXEC/STORE sequencer and program counter for the nibble datapath.
// Optional overflow trap enabled by defining NIBBLE_CTRL_OVF_TRAP_EN (adds the trap port).
module nibble_ctrl #(
   parameter int PC_W = 4,
   parameter int OP_W = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            run,
   input  logic [OP_W-1:0] op,
   input  logic [PC_W-1:0] addr,
   input  logic            alu_zero,
   input  logic            alu_ovf,
   output logic [PC_W-1:0] pc,
   output logic            ir_load,
   output logic            dec_load,
   output logic            alu_sub,
   output logic            ram_we,
   output logic            zflag,
   output logic            halted
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
  ,output logic            trap
`endif
);

   localparam logic [2:0] S_FETCH = 3'd0;
   localparam logic [2:0] S_IR    = 3'd1;
   localparam logic [2:0] S_DEC   = 3'd2;
   localparam logic [2:0] S_EXEC  = 3'd3;
   localparam logic [2:0] S_STORE = 3'd4;
   localparam logic [2:0] S_HALT  = 3'd5;

   localparam logic [OP_W-1:0] OP_ADD  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_SUB  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_MOV  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JMP  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_JZ   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_HALT = OP_W'(7);

   logic [2:0]      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            zflag_q, zflag_d;
   logic [OP_W-1:0] op_q, op_d;
   logic            arith_ex;

   // Opcode captured in EXEC so STORE-phase strobes come from local state only.
   assign arith_ex = (op == OP_ADD) || (op == OP_SUB);

`ifdef NIBBLE_CTRL_OVF_TRAP_EN
   logic trap_q, trap_d;
`else
   logic ovf_unused;
   assign ovf_unused = alu_ovf;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d = state_q;
      pc_d    = pc_q;
      zflag_d = zflag_q;
      op_d    = op_q;
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
      trap_d  = trap_q;
`endif
      case (state_q)
         S_FETCH: if (run) state_d = S_IR;
         S_IR:    state_d = S_DEC;
         S_DEC:   state_d = S_EXEC;
         S_EXEC: begin
            op_d = op;
            if (op == OP_HALT) begin
               state_d = S_HALT;
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
            end else if (arith_ex && alu_ovf) begin
               state_d = S_HALT;
               trap_d  = 1'b1;
`endif
            end else begin
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            if ((op_q == OP_ADD) || (op_q == OP_SUB)) zflag_d = alu_zero;
            // JZ tests the flag as it stood before this STORE.
            if ((op_q == OP_JMP) || ((op_q == OP_JZ) && zflag_q)) pc_d = addr;
            else                                                  pc_d = pc_q + 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         zflag_q <= 1'b0;
         op_q    <= '0;
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
         trap_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         zflag_q <= zflag_d;
         op_q    <= op_d;
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
         trap_q  <= trap_d;
`endif
      end
   end

   // In EXEC alu_sub uses the decode-field register output; in STORE it holds the captured opcode.
   assign alu_sub  = ((state_q == S_EXEC) && (op == OP_SUB)) ||
                     ((state_q == S_STORE) && (op_q == OP_SUB));
   assign ir_load  = (state_q == S_IR);
   assign dec_load = (state_q == S_DEC);
   assign ram_we   = (state_q == S_STORE) &&
                     ((op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MOV));
   assign halted   = (state_q == S_HALT);
   assign pc       = pc_q;
   assign zflag    = zflag_q;
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
   assign trap     = trap_q;
`endif

endmodule

// File: tb/tb_nibble_ctrl.sv
// Directed testbench for nibble_ctrl: opcode, address and ALU flags are driven straight onto the inputs.
module tb_nibble_ctrl;

   localparam logic [2:0] NOP  = 3'd0;
   localparam logic [2:0] ADD  = 3'd1;
   localparam logic [2:0] SUB  = 3'd2;
   localparam logic [2:0] MOV  = 3'd3;
   localparam logic [2:0] JMP  = 3'd4;
   localparam logic [2:0] JZ   = 3'd5;
   localparam logic [2:0] HALT = 3'd7;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [2:0] op = 3'd0;
   logic [3:0] addr = 4'd0;
   logic       alu_zero = 1'b0;
   logic       alu_ovf = 1'b0;
   logic [3:0] pc;
   logic       ir_load, dec_load, alu_sub, ram_we, zflag, halted;
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
   logic       trap;
`endif

   int checks = 0;
   int errors = 0;

   nibble_ctrl #(.PC_W(4), .OP_W(3)) dut (
      .clock    (clock),
      .reset    (reset),
      .run      (run),
      .op       (op),
      .addr     (addr),
      .alu_zero (alu_zero),
      .alu_ovf  (alu_ovf),
      .pc       (pc),
      .ir_load  (ir_load),
      .dec_load (dec_load),
      .alu_sub  (alu_sub),
      .ram_we   (ram_we),
      .zflag    (zflag),
      .halted   (halted)
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
     ,.trap     (trap)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      run = 1'b0; op = NOP; addr = 4'd0; alu_zero = 1'b0; alu_ovf = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      #1;
   endtask

   // Runs one instruction (5 cycles) starting in FETCH; counts strobe-high cycles.
   task automatic run_instr(input logic [2:0] o, input logic [3:0] a, input logic z, input logic v,
                            output int we_cnt, output int sub_cnt, output int ir_cnt);
      op = o; addr = a; alu_zero = z; alu_ovf = v; run = 1'b1;
      we_cnt = 0; sub_cnt = 0; ir_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         we_cnt  += int'(ram_we);
         sub_cnt += int'(alu_sub);
         ir_cnt  += int'(ir_load);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      checks++;
      if ({pc, zflag, halted, ir_load, dec_load, alu_sub, ram_we} !== 10'b0) begin
         errors++;
         $display("FAIL reset_values: pc=%0d z=%b h=%b ir=%b dec=%b sub=%b we=%b, expected all 0",
                  pc, zflag, halted, ir_load, dec_load, alu_sub, ram_we);
      end
   endtask

   task automatic test_nop_latency();
      logic [3:0] exp_pc [5];
      logic [1:0] exp_ld [5];
      do_reset();
      run = 1'b1; op = NOP;
      exp_pc = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
      exp_ld = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
      checks++;
      if ({ir_load, dec_load} !== 2'b00) begin
         errors++;
         $display("FAIL nop_cycle1_loads: ir/dec=%b, expected 00", {ir_load, dec_load});
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({ir_load, dec_load} !== exp_ld[i] || pc !== exp_pc[i] || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL nop_edge%0d: ir/dec=%b pc=%0d we=%b, expected ir/dec=%b pc=%0d we=0",
                     i + 1, {ir_load, dec_load}, pc, ram_we, exp_ld[i], exp_pc[i]);
         end
      end
   endtask

   task automatic test_run_hold();
      int bad = 0;
      do_reset();
      run = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pc !== 4'd0 || {ir_load, dec_load, alu_sub, ram_we} !== 4'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL run_hold: %0d bad cycles (last pc=%0d), expected 0", bad, pc);
      end
   endtask

   task automatic test_add_jz();
      int we, sb, ir;
      do_reset();
      for (int i = 0; i < 3; i++) run_instr(NOP, 4'd0, 1'b0, 1'b0, we, sb, ir);
      checks++;
      if (pc !== 4'd3) begin
         errors++;
         $display("FAIL add_jz_setup_pc: pc=%0d, expected 3", pc);
      end
      run_instr(ADD, 4'd0, 1'b1, 1'b0, we, sb, ir);
      checks++;
      if (we !== 1 || zflag !== 1'b1 || pc !== 4'd4 || sb !== 0) begin
         errors++;
         $display("FAIL add_zero: we_pulses=%0d z=%b pc=%0d sub=%0d, expected 1 1 4 0", we, zflag, pc, sb);
      end
      run_instr(JZ, 4'd9, 1'b0, 1'b0, we, sb, ir);
      checks++;
      if (pc !== 4'd9 || we !== 0 || zflag !== 1'b1) begin
         errors++;
         $display("FAIL jz_taken: pc=%0d we_pulses=%0d z=%b, expected 9 0 1", pc, we, zflag);
      end
      run_instr(SUB, 4'd0, 1'b0, 1'b0, we, sb, ir);
      checks++;
      if (we !== 1 || sb !== 2 || zflag !== 1'b0 || pc !== 4'd10) begin
         errors++;
         $display("FAIL sub_nonzero: we=%0d sub_cycles=%0d z=%b pc=%0d, expected 1 2 0 10", we, sb, zflag, pc);
      end
      run_instr(JZ, 4'd2, 1'b1, 1'b0, we, sb, ir);
      checks++;
      if (pc !== 4'd11 || zflag !== 1'b0) begin
         errors++;
         $display("FAIL jz_not_taken: pc=%0d z=%b, expected 11 0", pc, zflag);
      end
   endtask

   task automatic test_jmp_wrap();
      int we, sb, ir;
      do_reset();
      run_instr(JMP, 4'd15, 1'b0, 1'b0, we, sb, ir);
      checks++;
      if (pc !== 4'd15 || we !== 0) begin
         errors++;
         $display("FAIL jmp_15: pc=%0d we=%0d, expected 15 0", pc, we);
      end
      run_instr(NOP, 4'd0, 1'b1, 1'b0, we, sb, ir);
      checks++;
      if (pc !== 4'd0 || zflag !== 1'b0) begin
         errors++;
         $display("FAIL pc_wrap: pc=%0d z=%b, expected 0 0", pc, zflag);
      end
   endtask

   task automatic test_back_to_back();
      int we, sb, ir;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         run_instr(MOV, 4'd0, 1'b0, 1'b0, we, sb, ir);
         checks++;
         if (we !== 1 || ir !== 1 || sb !== 0 || pc !== 4'(i + 1)) begin
            errors++;
            $display("FAIL mov_b2b_%0d: we=%0d ir=%0d sub=%0d pc=%0d, expected 1 1 0 %0d", i, we, ir, sb, pc, i + 1);
         end
      end
   endtask

   task automatic test_run_drop();
      int irs = 0;
      do_reset();
      op = NOP; run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (pc !== 4'd1) begin
         errors++;
         $display("FAIL run_drop_inflight: pc=%0d, expected 1", pc);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         irs += int'(ir_load);
      end
      checks++;
      if (irs != 0 || pc !== 4'd1) begin
         errors++;
         $display("FAIL run_drop_stall: ir_pulses=%0d pc=%0d, expected 0 1", irs, pc);
      end
   endtask

   task automatic test_halt();
      int we, sb, ir, bad = 0;
      do_reset();
      for (int i = 0; i < 2; i++) run_instr(NOP, 4'd0, 1'b0, 1'b0, we, sb, ir);
      run_instr(HALT, 4'd0, 1'b0, 1'b0, we, sb, ir);
      checks++;
      if (halted !== 1'b1 || pc !== 4'd2 || we !== 0) begin
         errors++;
         $display("FAIL halt_enter: halted=%b pc=%0d we=%0d, expected 1 2 0", halted, pc, we);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (halted !== 1'b1 || pc !== 4'd2 || {ir_load, dec_load, alu_sub, ram_we} !== 4'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: %0d bad cycles, expected 0", bad);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (pc !== 4'd0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt_reset: pc=%0d halted=%b, expected 0 0", pc, halted);
      end
   endtask

   task automatic test_ovf();
      int we, sb, ir;
      do_reset();
      for (int i = 0; i < 6; i++) run_instr(NOP, 4'd0, 1'b0, 1'b0, we, sb, ir);
      run_instr(SUB, 4'd0, 1'b0, 1'b1, we, sb, ir);
`ifdef NIBBLE_CTRL_OVF_TRAP_EN
      checks++;
      if (we !== 0 || trap !== 1'b1 || halted !== 1'b1 || pc !== 4'd6) begin
         errors++;
         $display("FAIL ovf_trap: we=%0d trap=%b halted=%b pc=%0d, expected 0 1 1 6", we, trap, halted, pc);
      end
`else
      checks++;
      if (we !== 1 || halted !== 1'b0 || pc !== 4'd7) begin
         errors++;
         $display("FAIL ovf_ignored: we=%0d halted=%b pc=%0d, expected 1 0 7", we, halted, pc);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_nop_latency();
      test_run_hold();
      test_add_jz();
      test_jmp_wrap();
      test_back_to_back();
      test_run_drop();
      test_halt();
      test_ovf();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
